// File: rtl/panda_risc_v_pkg.sv
// Encodings shared by the write-back arbiter, dispatcher and commit logic.
// Source IDs appear on m_wbk_src; long indices drive the round-robin picker.
package panda_risc_v_pkg;

  localparam logic [2:0] SrcAlu = 3'd0;
  localparam logic [2:0] SrcLsu = 3'd1;
  localparam logic [2:0] SrcCsr = 3'd2;
  localparam logic [2:0] SrcMul = 3'd3;
  localparam logic [2:0] SrcDiv = 3'd4;

  localparam logic [1:0] LongLsu = 2'd0;
  localparam logic [1:0] LongCsr = 2'd1;
  localparam logic [1:0] LongMul = 2'd2;
  localparam logic [1:0] LongDiv = 2'd3;

  // Long index k maps to source ID k+1.
  function automatic logic [2:0] long_to_src(input logic [1:0] idx);
    return {1'b0, idx} + 3'd1;
  endfunction

endpackage

// File: rtl/panda_risc_v_rr_pick4.sv
// Four-way round-robin picker: searches requests starting one past the
// last winner, wrapping index 3 back to 0.
module panda_risc_v_rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] grant,
  output logic [1:0] idx,
  output logic       any
);

  logic       found;
  logic [1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = last;
    pos   = last;
    for (int k = 1; k <= 4; k++) begin
      pos = last + 2'(k);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    any   = |req;
    grant = any ? (4'b0001 << idx) : 4'b0000;
  end

endmodule

// File: rtl/panda_risc_v_wbk_arbiter.sv
// Write-back arbiter: five result sources into one registered regfile port.
// ALU has priority unless long-latency units have waited starve_thr cycles.
module panda_risc_v_wbk_arbiter
  import panda_risc_v_pkg::*;
#(
  parameter int unsigned inst_id_width = 4,
  parameter int unsigned starve_thr    = 4
) (
  input  logic                     clk,
  input  logic                     sys_reset,

  input  logic [31:0]              s_alu_wbk_data,
  input  logic [4:0]               s_alu_wbk_rd_id,
  input  logic                     s_alu_wbk_rd_vld,
  input  logic [inst_id_width-1:0] s_alu_wbk_inst_id,
  input  logic                     s_alu_wbk_valid,
  output logic                     s_alu_wbk_ready,

  input  logic [31:0]              s_lsu_wbk_data,
  input  logic [4:0]               s_lsu_wbk_rd_id,
  input  logic                     s_lsu_wbk_rd_vld,
  input  logic [inst_id_width-1:0] s_lsu_wbk_inst_id,
  input  logic                     s_lsu_wbk_valid,
  output logic                     s_lsu_wbk_ready,

  input  logic [31:0]              s_csr_wbk_data,
  input  logic [4:0]               s_csr_wbk_rd_id,
  input  logic                     s_csr_wbk_rd_vld,
  input  logic [inst_id_width-1:0] s_csr_wbk_inst_id,
  input  logic                     s_csr_wbk_valid,
  output logic                     s_csr_wbk_ready,

  input  logic [31:0]              s_mul_wbk_data,
  input  logic [4:0]               s_mul_wbk_rd_id,
  input  logic                     s_mul_wbk_rd_vld,
  input  logic [inst_id_width-1:0] s_mul_wbk_inst_id,
  input  logic                     s_mul_wbk_valid,
  output logic                     s_mul_wbk_ready,

  input  logic [31:0]              s_div_wbk_data,
  input  logic [4:0]               s_div_wbk_rd_id,
  input  logic                     s_div_wbk_rd_vld,
  input  logic [inst_id_width-1:0] s_div_wbk_inst_id,
  input  logic                     s_div_wbk_valid,
  output logic                     s_div_wbk_ready,

  output logic [31:0]              m_wbk_data,
  output logic [4:0]               m_wbk_rd_id,
  output logic                     m_wbk_rd_vld,
  output logic [inst_id_width-1:0] m_wbk_inst_id,
  output logic [2:0]               m_wbk_src,
  output logic                     m_wbk_valid,
  input  logic                     m_wbk_ready
);

  logic                     slot_vld_q;
  logic [31:0]              slot_data_q;
  logic [4:0]               slot_rd_id_q;
  logic                     slot_rd_vld_q;
  logic [inst_id_width-1:0] slot_inst_id_q;
  logic [2:0]               slot_src_q;
  logic [1:0]               rr_last_q, rr_last_d;
  logic [2:0]               starve_cnt_q, starve_cnt_d;

  logic [3:0] long_vld, pick_grant;
  logic [1:0] pick_idx;
  logic       pick_any, grant_ok, starved, alu_win, grant_alu, grant_long;
  logic [2:0] sel_src;

  logic [31:0]              sel_data;
  logic [4:0]               sel_rd_id;
  logic                     sel_rd_vld;
  logic [inst_id_width-1:0] sel_inst_id;

  assign long_vld = {s_div_wbk_valid, s_mul_wbk_valid, s_csr_wbk_valid, s_lsu_wbk_valid};

  panda_risc_v_rr_pick4 u_pick (
    .req   (long_vld),
    .last  (rr_last_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign grant_ok   = ~sys_reset & (~slot_vld_q | m_wbk_ready);
  assign starved    = 32'(starve_cnt_q) >= starve_thr;
  assign alu_win    = s_alu_wbk_valid & ~(starved & pick_any);
  assign grant_alu  = grant_ok & alu_win;
  assign grant_long = grant_ok & ~alu_win & pick_any;
  assign sel_src    = alu_win ? SrcAlu : long_to_src(pick_idx);

  assign s_alu_wbk_ready = grant_alu;
  assign s_lsu_wbk_ready = grant_long & pick_grant[LongLsu];
  assign s_csr_wbk_ready = grant_long & pick_grant[LongCsr];
  assign s_mul_wbk_ready = grant_long & pick_grant[LongMul];
  assign s_div_wbk_ready = grant_long & pick_grant[LongDiv];

  always_comb begin
    sel_data    = s_alu_wbk_data;
    sel_rd_id   = s_alu_wbk_rd_id;
    sel_rd_vld  = s_alu_wbk_rd_vld;
    sel_inst_id = s_alu_wbk_inst_id;
    unique case (sel_src)
      SrcLsu: begin
        sel_data = s_lsu_wbk_data; sel_rd_id = s_lsu_wbk_rd_id;
        sel_rd_vld = s_lsu_wbk_rd_vld; sel_inst_id = s_lsu_wbk_inst_id;
      end
      SrcCsr: begin
        sel_data = s_csr_wbk_data; sel_rd_id = s_csr_wbk_rd_id;
        sel_rd_vld = s_csr_wbk_rd_vld; sel_inst_id = s_csr_wbk_inst_id;
      end
      SrcMul: begin
        sel_data = s_mul_wbk_data; sel_rd_id = s_mul_wbk_rd_id;
        sel_rd_vld = s_mul_wbk_rd_vld; sel_inst_id = s_mul_wbk_inst_id;
      end
      SrcDiv: begin
        sel_data = s_div_wbk_data; sel_rd_id = s_div_wbk_rd_id;
        sel_rd_vld = s_div_wbk_rd_vld; sel_inst_id = s_div_wbk_inst_id;
      end
      default: ;
    endcase
  end

  // Waiting counts up whenever a long result is pending but not taken,
  // including cycles lost to output backpressure.
  always_comb begin
    rr_last_d    = rr_last_q;
    starve_cnt_d = starve_cnt_q;
    if (grant_long) begin
      rr_last_d    = pick_idx;
      starve_cnt_d = 3'd0;
    end else if (pick_any && starve_cnt_q != 3'd7) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      slot_vld_q     <= 1'b0;
      slot_data_q    <= '0;
      slot_rd_id_q   <= '0;
      slot_rd_vld_q  <= 1'b0;
      slot_inst_id_q <= '0;
      slot_src_q     <= '0;
      rr_last_q      <= LongDiv;
      starve_cnt_q   <= 3'd0;
    end else begin
      rr_last_q    <= rr_last_d;
      starve_cnt_q <= starve_cnt_d;
      if (grant_alu || grant_long) begin
        slot_vld_q     <= 1'b1;
        slot_data_q    <= sel_data;
        slot_rd_id_q   <= sel_rd_id;
        slot_rd_vld_q  <= sel_rd_vld;
        slot_inst_id_q <= sel_inst_id;
        slot_src_q     <= sel_src;
      end else if (m_wbk_ready) begin
        slot_vld_q <= 1'b0;
      end
    end
  end

  assign m_wbk_valid   = slot_vld_q & ~sys_reset;
  assign m_wbk_data    = slot_data_q;
  assign m_wbk_rd_id   = slot_rd_id_q;
  assign m_wbk_rd_vld  = slot_rd_vld_q;
  assign m_wbk_inst_id = slot_inst_id_q;
  assign m_wbk_src     = slot_src_q;

endmodule

// File: tb/tb_panda_risc_v_wbk_arbiter.sv
// Bench for the write-back arbiter: directed scenarios plus random traffic,
// all compared against a per-cycle behavioural model of the arbitration rules.
module tb_panda_risc_v_wbk_arbiter;

  localparam int Thr = 4;

  logic        clk = 1'b0;
  logic        sys_reset;
  logic [31:0] d   [5];
  logic [4:0]  rd  [5];
  logic        rv  [5];
  logic [3:0]  id  [5];
  logic        v   [5];
  logic [4:0]  rdy;
  logic [31:0] m_wbk_data;
  logic [4:0]  m_wbk_rd_id;
  logic        m_wbk_rd_vld;
  logic [3:0]  m_wbk_inst_id;
  logic [2:0]  m_wbk_src;
  logic        m_wbk_valid;
  logic        m_wbk_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: index 0 = ALU, 1..4 = LSU, CSR, MUL, DIV.
  bit          m_vld;
  int          m_rr, m_sc;
  logic [31:0] e_data;
  logic [4:0]  e_rd;
  logic        e_rv;
  logic [3:0]  e_id;
  int          e_src;

  always #5 clk = ~clk;

  panda_risc_v_wbk_arbiter #(.inst_id_width(4), .starve_thr(Thr)) dut (
    .clk(clk), .sys_reset(sys_reset),
    .s_alu_wbk_data(d[0]), .s_alu_wbk_rd_id(rd[0]), .s_alu_wbk_rd_vld(rv[0]),
    .s_alu_wbk_inst_id(id[0]), .s_alu_wbk_valid(v[0]), .s_alu_wbk_ready(rdy[0]),
    .s_lsu_wbk_data(d[1]), .s_lsu_wbk_rd_id(rd[1]), .s_lsu_wbk_rd_vld(rv[1]),
    .s_lsu_wbk_inst_id(id[1]), .s_lsu_wbk_valid(v[1]), .s_lsu_wbk_ready(rdy[1]),
    .s_csr_wbk_data(d[2]), .s_csr_wbk_rd_id(rd[2]), .s_csr_wbk_rd_vld(rv[2]),
    .s_csr_wbk_inst_id(id[2]), .s_csr_wbk_valid(v[2]), .s_csr_wbk_ready(rdy[2]),
    .s_mul_wbk_data(d[3]), .s_mul_wbk_rd_id(rd[3]), .s_mul_wbk_rd_vld(rv[3]),
    .s_mul_wbk_inst_id(id[3]), .s_mul_wbk_valid(v[3]), .s_mul_wbk_ready(rdy[3]),
    .s_div_wbk_data(d[4]), .s_div_wbk_rd_id(rd[4]), .s_div_wbk_rd_vld(rv[4]),
    .s_div_wbk_inst_id(id[4]), .s_div_wbk_valid(v[4]), .s_div_wbk_ready(rdy[4]),
    .m_wbk_data(m_wbk_data), .m_wbk_rd_id(m_wbk_rd_id), .m_wbk_rd_vld(m_wbk_rd_vld),
    .m_wbk_inst_id(m_wbk_inst_id), .m_wbk_src(m_wbk_src), .m_wbk_valid(m_wbk_valid),
    .m_wbk_ready(m_wbk_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winning source under the priority rules, or -1 if nothing is valid.
  function automatic int winner();
    int  w = -1;
    bit  any_long = v[1] | v[2] | v[3] | v[4];
    if (v[0] && !(m_sc >= Thr && any_long)) begin
      w = 0;
    end else if (any_long) begin
      for (int k = 1; k <= 4; k++) begin
        int i = (m_rr + k) % 4;
        if (w < 0 && v[i + 1]) w = i + 1;
      end
    end
    return w;
  endfunction

  task automatic tick();
    int         w;
    bit         allow, g, any_long;
    logic [4:0] exp_rdy;
    #1;
    w        = winner();
    any_long = v[1] | v[2] | v[3] | v[4];
    allow    = !sys_reset && (!m_vld || m_wbk_ready);
    g        = allow && (w >= 0);
    exp_rdy  = g ? 5'(1 << w) : 5'd0;
    check("ready", rdy, exp_rdy);
    check("m_valid", m_wbk_valid, m_vld && !sys_reset);
    if (m_vld && !sys_reset) begin
      check("m_data", m_wbk_data, e_data);
      check("m_rd_id", m_wbk_rd_id, e_rd);
      check("m_rd_vld", m_wbk_rd_vld, e_rv);
      check("m_inst_id", m_wbk_inst_id, e_id);
      check("m_src", m_wbk_src, e_src);
    end
    @(posedge clk);
    if (sys_reset) begin
      m_vld = 0; m_rr = 3; m_sc = 0;
      e_data = '0; e_rd = '0; e_rv = 0; e_id = '0; e_src = 0;
    end else begin
      if (g) begin
        m_vld = 1; e_data = d[w]; e_rd = rd[w]; e_rv = rv[w]; e_id = id[w]; e_src = w;
      end else if (m_vld && m_wbk_ready) begin
        m_vld = 0;
      end
      if (g && w > 0) begin
        m_rr = w - 1; m_sc = 0;
      end else if (any_long && m_sc < 7) begin
        m_sc++;
      end
    end
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < 5; i++) begin
      v[i] = 0; d[i] = 32'h100 * (i + 1); rd[i] = 5'(i + 1); rv[i] = 1; id[i] = 4'(i);
    end
  endtask

  task automatic do_reset();
    idle();
    sys_reset = 1;
    tick();
    sys_reset = 0;
  endtask

  initial begin
    sys_reset = 1; m_wbk_ready = 1;
    m_vld = 0; m_rr = 3; m_sc = 0;
    idle();
    tick();
    tick();
    sys_reset = 0;

    // ALU-only single result
    v[0] = 1; d[0] = 32'h1234; rd[0] = 5'd5; id[0] = 4'd3;
    #1 check("alu_ready_same_cycle", rdy[0], 1'b1);
    tick();
    v[0] = 0;
    check("alu_m_valid", m_wbk_valid, 1'b1);
    check("alu_m_data", m_wbk_data, 32'h1234);
    check("alu_m_rd", m_wbk_rd_id, 5'd5);
    check("alu_m_src", m_wbk_src, 3'd0);
    tick();

    // Round robin over LSU, MUL, DIV
    do_reset();
    v[1] = 1; v[3] = 1; v[4] = 1; m_wbk_ready = 1;
    tick(); check("rr_0_lsu", m_wbk_src, 3'd1);
    tick(); check("rr_1_mul", m_wbk_src, 3'd3);
    tick(); check("rr_2_div", m_wbk_src, 3'd4);
    tick(); check("rr_3_lsu", m_wbk_src, 3'd1);

    // Starvation: ALU for four grants, then MUL, then ALU again
    do_reset();
    v[0] = 1; v[3] = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("starve_c%0d", c), m_wbk_src, (c == 4) ? 3'd3 : 3'd0);
    end

    // Backpressure with stall then drain-and-reload
    do_reset();
    v[0] = 1; d[0] = 32'hAAAA_0001; m_wbk_ready = 0;
    tick();
    for (int c = 0; c < 3; c++) begin
      d[0] = 32'hBBBB_0000 + 32'(c);
      tick();
      check("bp_hold_data", m_wbk_data, 32'hAAAA_0001);
      check("bp_hold_valid", m_wbk_valid, 1'b1);
    end
    m_wbk_ready = 1; d[0] = 32'hCCCC_0002;
    tick();
    check("bp_reload_valid", m_wbk_valid, 1'b1);
    check("bp_reload_data", m_wbk_data, 32'hCCCC_0002);
    v[0] = 0;
    tick();

    // Reset discards a held DIV result
    do_reset();
    v[4] = 1; m_wbk_ready = 0;
    tick();
    check("div_held_src", m_wbk_src, 3'd4);
    v[4] = 0; sys_reset = 1;
    tick();
    sys_reset = 0;
    check("rst_valid_low", m_wbk_valid, 1'b0);
    m_wbk_ready = 1; v[1] = 1; v[2] = 1; v[3] = 1; v[4] = 1;
    tick();
    check("rst_rr_lsu_first", m_wbk_src, 3'd1);

    // CSR result without register write
    do_reset();
    v[2] = 1; rv[2] = 0;
    tick();
    check("csr_rd_vld", m_wbk_rd_vld, 1'b0);
    check("csr_src", m_wbk_src, 3'd2);
    v[2] = 0;
    tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 5; i++) begin
        v[i]  = ($urandom_range(0, 99) < 45);
        d[i]  = $urandom;
        rd[i] = 5'($urandom);
        rv[i] = 1'($urandom);
        id[i] = 4'($urandom);
      end
      m_wbk_ready = ($urandom_range(0, 99) < 70);
      sys_reset   = ($urandom_range(0, 99) < 2);
      tick();
    end
    sys_reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/panda_risc_v_wbk_arbiter.md
PANDA_RISC_V_WBK_ARBITER -- requirements
Module: panda_risc_v_wbk_arbiter

Interface
REQ-001 The block SHALL have parameter inst_id_width, default 4, meaning instruction ID width.
REQ-002 The block SHALL have parameter starve_thr, default 4, meaning wait cycles after which long-unit results outrank ALU (range 1..7).
REQ-003 The block SHALL have port clk  input  1  clock; everything is in this single clock domain.
REQ-004 The block SHALL have port sys_reset  input  1  reset, synchronous and active-high.
REQ-005 For each source X in {alu, lsu, csr, mul, div}, the block SHALL have these slave write-back ports:
- s_X_wbk_data  input  32  result
- s_X_wbk_rd_id  input  5  RD index
- s_X_wbk_rd_vld  input  1  write RD
- s_X_wbk_inst_id  input  inst_id_width  instruction ID
- s_X_wbk_valid  input  1  valid
- s_X_wbk_ready  output  1  ready
REQ-006 The block SHALL have these master regfile write-back ports:
- m_wbk_data  output  32  result
- m_wbk_rd_id  output  5  RD index
- m_wbk_rd_vld  output  1  write enable
- m_wbk_inst_id  output  inst_id_width  instruction ID
- m_wbk_src  output  3  granted source (0 ALU, 1 LSU, 2 CSR, 3 MUL, 4 DIV)
- m_wbk_valid  output  1  valid
- m_wbk_ready  input  1  ready

Function
REQ-007 The block SHALL hold one output register slot; a grant SHALL be allowed only in a cycle where slot empty or m_wbk_ready=1.
REQ-008 At most one s_X_wbk_ready SHALL be 1 per cycle; it SHALL be 1 only for the granted source, in a grant-allowed cycle, with its valid=1 (ready may depend on valid).
REQ-009 The granted source's fields SHALL be captured into the slot on the grant edge; m_wbk_valid SHALL assert the next cycle (latency 1).
REQ-010 The slot SHALL clear when m_wbk_valid & m_wbk_ready with no new grant; with a simultaneous grant it SHALL be reloaded with no bubble.
REQ-011 While m_wbk_valid=1 & m_wbk_ready=0, the slot SHALL hold every output stable.
REQ-012 Priority: ALU SHALL win whenever valid, unless starve_cnt >= starve_thr and any long source is valid, in which case a long source SHALL win.
REQ-013 Among long sources (LSU=0, CSR=1, MUL=2, DIV=3), the grant SHALL be round-robin; the search SHALL start at rr_last+1 mod 4 (wrap DIV->LSU).
REQ-014 rr_last (2 bits) SHALL update to the granted long index only on a long-source handshake.
REQ-015 starve_cnt (3 bits, saturating at 7) SHALL increment in any cycle where at least one long source is valid and no long source is granted; it SHALL clear on any long-source handshake; it SHALL otherwise hold.
REQ-016 rd_vld=0 results SHALL still be arbitrated and forwarded, with m_wbk_rd_vld=0.
REQ-017 When no source is valid, no ready SHALL assert and rr_last and starve_cnt SHALL hold.

Reset
REQ-018 In a cycle with sys_reset=1, the block SHALL force m_wbk_valid=0, rr_last=3 (so LSU is searched first), and starve_cnt=0, and SHALL de-assert all s_X_wbk_ready combinationally.
REQ-019 Slot data outputs SHALL reset to 0.
REQ-020 Reset mid-transfer SHALL discard the held slot without a handshake.

Structure
REQ-021 Source encodings (0..4) and the long-index encoding SHALL be localparams shared in the panda_risc_v package with the dispatcher/commit logic.
REQ-022 The round-robin 4-way picker (request[3:0], last[1:0] -> grant one-hot and index) SHALL be the single sub-module panda_risc_v_rr_pick4.

Verification
REQ-023 ALU only: ALU valid, data 0x1234, rd 5, id 3 -> alu ready same cycle; m_wbk_valid next cycle with m_wbk_data 0x1234, m_wbk_rd_id 5, m_wbk_src 0.
REQ-024 Round robin: after reset, LSU, MUL and DIV held valid, m_wbk_ready=1 -> grant order LSU, MUL, DIV, LSU.
REQ-025 Starvation, starve_thr=4: ALU valid every cycle and MUL valid from cycle 0 -> ALU granted in cycles 0-3; MUL granted in cycle 4; starve_cnt then 0.
REQ-026 Backpressure: m_wbk_ready=0 for 3 cycles with the slot full -> outputs stable and no ready asserted; ready=1 -> drain and reload in the same cycle with no bubble.
REQ-027 Reset in the cycle after a DIV grant, with the slot holding DIV data -> m_wbk_valid=0 the next cycle, rr_last=3, starve_cnt=0.
REQ-028 CSR result with rd_vld=0 -> forwarded with m_wbk_rd_vld=0 and m_wbk_src 2.
